// File: rtl/rf_pulse_pkg.sv
// Shared definitions for the RF pulse link (transmitter and receiver).
package rf_pulse_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PREAMBLE = 2'd1,
    DATA     = 2'd2,
    FINISH   = 2'd3
  } rf_tx_state_t;

  localparam int RF_PREAMBLE_BITS = 8;
  localparam int RF_DATA_BITS     = 64;

  // Default bit timing at a 10 MHz PCLK: 1 ms bit period, 100 ns pulse at 50 %.
  localparam int RF_BIT_CYCLES    = 10000;
  localparam int RF_PULSE_POS     = 5000;
  localparam int RF_PULSE_CYCLES  = 1;

  function automatic int rf_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/rf_bit_timer.sv
// Cycle counter k within one bit period, with period-end and pulse-window flags.
// pulse_win looks at the count being loaded for the next cycle, so a flop fed
// from it is high exactly on the cycles where k sits inside the window.
module rf_bit_timer #(
  parameter int BIT_CYCLES   = 10000,
  parameter int PULSE_POS    = 5000,
  parameter int PULSE_CYCLES = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  output logic period_end,
  output logic pulse_win
);

  localparam int KW = $clog2(BIT_CYCLES);
  localparam logic [KW-1:0] K_LAST    = KW'(BIT_CYCLES - 1);
  localparam logic [KW-1:0] WIN_FIRST = KW'(PULSE_POS);
  localparam logic [KW-1:0] WIN_LAST  = KW'(PULSE_POS + PULSE_CYCLES - 1);

  logic [KW-1:0] k_q;
  logic [KW-1:0] k_d;

  assign period_end = (k_q == K_LAST);
  assign pulse_win  = (k_d >= WIN_FIRST) && (k_d <= WIN_LAST);

  // Count while a frame runs, wrapping at the period end; park at 0 otherwise.
  always_comb begin
    k_d = '0;
    if (run && !period_end) begin
      k_d = k_q + KW'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      k_q <= '0;
    end else begin
      k_q <= k_d;
    end
  end

endmodule

// File: rtl/rf_pulse_tx.sv
// RF pulse transmitter: preamble of one-bits then the packet MSB first, OOK pulses.
module rf_pulse_tx
  import rf_pulse_pkg::*;
#(
  parameter int BIT_CYCLES    = RF_BIT_CYCLES,
  parameter int PULSE_POS     = RF_PULSE_POS,
  parameter int PULSE_CYCLES  = RF_PULSE_CYCLES,
  parameter int PREAMBLE_BITS = RF_PREAMBLE_BITS,
  parameter int DATA_BITS     = RF_DATA_BITS
) (
  input  logic                 i_PCLK,
  input  logic                 i_PRESETn,
  input  logic                 i_START,
  input  logic                 i_ABORT,
  input  logic [DATA_BITS-1:0] i_PACKET,
  output logic                 o_RFOUT,
  output logic                 o_BUSY,
  output logic                 o_DONE,
  output logic                 o_ABORTED
);

  localparam int BCW = $clog2(rf_max(PREAMBLE_BITS, DATA_BITS)) + 1;
  localparam logic [BCW-1:0] PRE_LAST = BCW'(PREAMBLE_BITS - 1);
  localparam logic [BCW-1:0] DAT_LAST = BCW'(DATA_BITS - 1);

  rf_tx_state_t         state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [BCW-1:0]       bit_cnt_q, bit_cnt_d;
  logic                 rfout_q, rfout_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 aborted_q, aborted_d;
  logic                 timer_run;
  logic                 period_end;
  logic                 pulse_win;

  // The bit timer only advances while a frame is running and not being aborted.
  assign timer_run = ((state_q == PREAMBLE) || (state_q == DATA)) && !i_ABORT;

  rf_bit_timer #(
    .BIT_CYCLES  (BIT_CYCLES),
    .PULSE_POS   (PULSE_POS),
    .PULSE_CYCLES(PULSE_CYCLES)
  ) u_timer (
    .clk       (i_PCLK),
    .rst_n     (i_PRESETn),
    .run       (timer_run),
    .period_end(period_end),
    .pulse_win (pulse_win)
  );

  // Next-state, shift register, bit counter and registered-output decode.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    aborted_d = 1'b0;
    unique case (state_q)
      IDLE, FINISH: begin
        state_d = IDLE;
        if (i_START) begin
          state_d   = PREAMBLE;
          shift_d   = i_PACKET;
          bit_cnt_d = '0;
        end
      end
      PREAMBLE: begin
        if (i_ABORT) begin
          state_d   = IDLE;
          bit_cnt_d = '0;
          aborted_d = 1'b1;
        end else if (period_end) begin
          if (bit_cnt_q == PRE_LAST) begin
            state_d   = DATA;
            bit_cnt_d = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + BCW'(1);
          end
        end
      end
      DATA: begin
        if (i_ABORT) begin
          state_d   = IDLE;
          bit_cnt_d = '0;
          aborted_d = 1'b1;
        end else if (period_end) begin
          shift_d = shift_q << 1;
          if (bit_cnt_q == DAT_LAST) begin
            state_d   = FINISH;
            bit_cnt_d = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + BCW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d  = (state_d == PREAMBLE) || (state_d == DATA);
    done_d  = (state_d == FINISH);
    rfout_d = pulse_win &&
              ((state_d == PREAMBLE) || ((state_d == DATA) && shift_d[DATA_BITS-1]));
  end

  // State, datapath and output registers with synchronous active-low reset.
  always_ff @(posedge i_PCLK) begin
    if (!i_PRESETn) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      rfout_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      rfout_q   <= rfout_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
    end
  end

  assign o_RFOUT   = rfout_q;
  assign o_BUSY    = busy_q;
  assign o_DONE    = done_q;
  assign o_ABORTED = aborted_q;

endmodule

// File: tb/tb_rf_pulse_tx.sv
// Testbench for rf_pulse_tx: frame-level reference model plus literal pins.
module tb_rf_pulse_tx;

  localparam int BC    = 20;
  localparam int PP    = 10;
  localparam int PW    = 2;
  localparam int NPRE  = 8;
  localparam int NDAT  = 64;
  localparam int FRAME = (NPRE + NDAT) * BC;

  logic        clk    = 1'b0;
  logic        rstn   = 1'b0;
  logic        start  = 1'b0;
  logic        abort  = 1'b0;
  logic [63:0] packet = '0;
  logic        rfout, busy, done, aborted;

  logic        start2  = 1'b0;
  logic        abort2  = 1'b0;
  logic [63:0] packet2 = '0;
  logic        rfout2, busy2, done2, aborted2;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  rf_pulse_tx #(
    .BIT_CYCLES   (BC),
    .PULSE_POS    (PP),
    .PULSE_CYCLES (PW),
    .PREAMBLE_BITS(NPRE),
    .DATA_BITS    (NDAT)
  ) dut (
    .i_PCLK   (clk),
    .i_PRESETn(rstn),
    .i_START  (start),
    .i_ABORT  (abort),
    .i_PACKET (packet),
    .o_RFOUT  (rfout),
    .o_BUSY   (busy),
    .o_DONE   (done),
    .o_ABORTED(aborted)
  );

  rf_pulse_tx dut_dflt (
    .i_PCLK   (clk),
    .i_PRESETn(rstn),
    .i_START  (start2),
    .i_ABORT  (abort2),
    .i_PACKET (packet2),
    .o_RFOUT  (rfout2),
    .o_BUSY   (busy2),
    .o_DONE   (done2),
    .o_ABORTED(aborted2)
  );

  task automatic check_output(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h at t=%0t", name, actual, expected, $time);
    end
  endtask

  // Reference model: m_c is the number of cycles since the frame's first busy cycle.
  bit          m_act = 1'b0;
  bit          m_abt = 1'b0;
  int          m_c   = 0;
  logic [63:0] m_pkt = '0;
  bit          chk_en = 1'b0;

  always @(posedge clk) begin
    if (!rstn) begin
      m_act = 1'b0;
      m_abt = 1'b0;
      m_c   = 0;
    end else begin
      m_abt = 1'b0;
      if (m_act && m_c < FRAME && abort) begin
        m_act = 1'b0;
        m_abt = 1'b1;
      end else if ((!m_act || m_c == FRAME) && start) begin
        m_act = 1'b1;
        m_c   = 0;
        m_pkt = packet;
      end else if (m_act && m_c == FRAME) begin
        m_act = 1'b0;
      end else if (m_act) begin
        m_c++;
      end
    end
  end

  function automatic logic [3:0] model_out();
    bit bsy, dn, rf, bitv;
    int b, k;
    bsy = m_act && (m_c < FRAME);
    dn  = m_act && (m_c == FRAME);
    rf  = 1'b0;
    if (bsy) begin
      b    = m_c / BC;
      k    = m_c % BC;
      bitv = (b < NPRE) ? 1'b1 : m_pkt[NDAT - 1 - (b - NPRE)];
      rf   = bitv && (k >= PP) && (k < PP + PW);
    end
    return {rf, bsy, dn, m_abt};
  endfunction

  // Every cycle: DUT outputs against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check_output("outs{rf,busy,done,aborted}", 64'({rfout, busy, done, aborted}),
                   64'(model_out()));
    end
  end

  // Activity counters for the literal checks.
  int   n_rf, n_rise, n_busy, n_done, n_abt, n_cyc, first_rise;
  logic rf_prev = 1'b0;

  always @(negedge clk) begin
    if (rfout === 1'b1 && rf_prev !== 1'b1) begin
      n_rise++;
      if (first_rise < 0) first_rise = n_cyc;
    end
    if (rfout === 1'b1) n_rf++;
    if (busy === 1'b1) n_busy++;
    if (done === 1'b1) n_done++;
    if (aborted === 1'b1) n_abt++;
    n_cyc++;
    rf_prev = rfout;
  end

  task automatic clear_counts();
    n_rf = 0; n_rise = 0; n_busy = 0; n_done = 0; n_abt = 0; n_cyc = 0;
    first_rise = -1;
  endtask

  task automatic apply_stimulus(input logic s, input logic a, input logic [63:0] p);
    @(negedge clk);
    start  = s;
    abort  = a;
    packet = p;
  endtask

  // Start a frame, optionally re-pulse start mid-frame, and wait for done.
  task automatic run_frame(input logic [63:0] pkt, input int inj_cycle,
                           input logic [63:0] inj_pkt);
    bit seen;
    seen = 1'b0;
    apply_stimulus(1'b1, 1'b0, pkt);
    @(posedge clk);
    #1 clear_counts();
    for (int i = 0; i < FRAME + 20; i++) begin
      @(negedge clk);
      if (i == 0) start = 1'b0;
      if (i == inj_cycle) begin
        start  = 1'b1;
        packet = inj_pkt;
      end
      if (i == inj_cycle + 1) start = 1'b0;
      if (done === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) check_output("frame_done_timeout", 64'd0, 64'd1);
    @(negedge clk);
  endtask

  task automatic wait_rf(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 4 * BC; i++) begin
      @(negedge clk);
      if (rfout === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check_output("wait_rf_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    #1_500_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    bit ok;
    int gap;
    int rises[3];
    int nr;
    logic prev2;

    // Reset, then idle for 100 cycles.
    repeat (3) @(posedge clk);
    #1 chk_en = 1'b1;
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1 clear_counts();
    repeat (100) @(negedge clk);
    check_output("idle_activity", 64'(n_rf + n_busy + n_done + n_abt), 64'd0);

    // Normal frame.
    run_frame(64'h8123456789ABCD0F, -10, 64'd0);
    check_output("normal_first_rise", 64'(first_rise), 64'(PP));
    check_output("normal_pulses", 64'(n_rise), 64'd38);
    check_output("normal_rf_cycles", 64'(n_rf), 64'd76);
    check_output("normal_busy_cycles", 64'(n_busy), 64'd1440);
    check_output("normal_done_cycles", 64'(n_done), 64'd1);

    // All-zero packet.
    run_frame(64'h0, -10, 64'd0);
    check_output("zero_pulses", 64'(n_rise), 64'd8);

    // Start while busy at bit 30.
    run_frame(64'h8123456789ABCD0F, 30 * BC, 64'hFFFF_FFFF_FFFF_FFFF);
    check_output("busy_start_pulses", 64'(n_rise), 64'd38);
    check_output("busy_start_busy_cycles", 64'(n_busy), 64'd1440);

    // Abort mid-pulse.
    apply_stimulus(1'b1, 1'b0, {$urandom, $urandom});
    @(posedge clk);
    #1 clear_counts();
    @(negedge clk);
    start = 1'b0;
    wait_rf(ok);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check_output("abort_rf", 64'(rfout), 64'd0);
    check_output("abort_busy", 64'(busy), 64'd0);
    check_output("abort_pulse", 64'(aborted), 64'd1);
    repeat (50) @(negedge clk);
    check_output("abort_no_done", 64'(n_done), 64'd0);

    // Reset mid-pulse.
    apply_stimulus(1'b1, 1'b0, {$urandom, $urandom});
    @(negedge clk);
    start = 1'b0;
    wait_rf(ok);
    rstn = 1'b0;
    @(negedge clk);
    check_output("reset_outs", 64'({rfout, busy, done, aborted}), 64'd0);
    rstn = 1'b1;
    @(posedge clk);
    #1 clear_counts();
    repeat (60) @(negedge clk);
    check_output("reset_discards", 64'(n_busy + n_rf), 64'd0);

    // Back-to-back frames with start held high.
    apply_stimulus(1'b1, 1'b0, 64'h00FF_00FF_1234_5678);
    @(negedge clk);
    packet = 64'hA5A5_0000_FFFF_0001;
    ok = 1'b0;
    for (int i = 0; i < FRAME + 20; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check_output("b2b_done_timeout", 64'd0, 64'd1);
    gap = -1;
    for (int g = 1; g <= 40; g++) begin
      @(negedge clk);
      if (rfout === 1'b1) begin
        gap = g;
        break;
      end
    end
    check_output("b2b_gap", 64'(gap), 64'd11);
    start = 1'b0;
    repeat (5 * BC) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check_output("b2b_abort_pulse", 64'(aborted), 64'd1);

    // Randomised traffic against the model.
    for (int cyc = 0; cyc < 6000; cyc++) begin
      @(negedge clk);
      start  = ($urandom_range(0, 59) == 0);
      abort  = ($urandom_range(0, 1999) == 0);
      rstn   = ($urandom_range(0, 4999) != 0);
      packet = {$urandom, $urandom};
    end
    @(negedge clk);
    rstn  = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    repeat (5) @(negedge clk);

    // Default parameters: preamble pulse spacing.
    nr = 0;
    prev2 = 1'b0;
    @(negedge clk);
    start2  = 1'b1;
    packet2 = {$urandom, $urandom};
    for (int idx = 0; idx < 30000; idx++) begin
      @(negedge clk);
      if (idx == 0) start2 = 1'b0;
      if (rfout2 === 1'b1 && prev2 !== 1'b1) begin
        rises[nr] = idx;
        nr++;
      end
      prev2 = rfout2;
      if (nr == 3) break;
    end
    check_output("dflt_pulse_count", 64'(nr), 64'd3);
    if (nr == 3) begin
      check_output("dflt_first_rise", 64'(rises[0]), 64'd5000);
      check_output("dflt_spacing1", 64'(rises[1] - rises[0]), 64'd10000);
      check_output("dflt_spacing2", 64'(rises[2] - rises[1]), 64'd10000);
    end
    check_output("dflt_busy", 64'(busy2), 64'd1);
    abort2 = 1'b1;
    @(negedge clk);
    abort2 = 1'b0;
    check_output("dflt_aborted", 64'({busy2, aborted2}), 64'b01);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
